// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared CPU constants and typedefs
package cpu_defs_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regaddr_t;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam word_t NOP_WORD    = 32'h0000_0000;
  localparam word_t RESET_PC    = 32'h0000_3000;
  localparam word_t HANDLER_ADR = 32'h0000_4180;

endpackage

// File: rtl/exc_merge.sv
// rtl/exc_merge.sv - priority merge of carried and ALU exceptions plus bad-address select
module exc_merge
  import cpu_defs_pkg::*;
(
  input  logic       exc_in,
  input  logic [4:0] exccode_in,
  input  logic       alu_err,
  input  logic [4:0] alu_exccode,
  input  word_t      pc,
  input  word_t      alu_result,
  output logic       exc,
  output logic [4:0] exccode,
  output word_t      badvaddr
);

  // Earlier stage wins; the faulting address follows whichever report won.
  always_comb begin
    exc      = 1'b0;
    exccode  = 5'd0;
    badvaddr = '0;
    if (exc_in) begin
      exc     = 1'b1;
      exccode = exccode_in;
      if (exccode_in == EXC_ADEL) badvaddr = pc;
    end else if (alu_err) begin
      exc     = 1'b1;
      exccode = alu_exccode;
      if ((alu_exccode == EXC_ADEL) || (alu_exccode == EXC_ADES)) badvaddr = alu_result;
    end
  end

endmodule

// File: rtl/pipe_reg_em.sv
// rtl/pipe_reg_em.sv - E->M pipeline register with exception merge (optional EM_BADVADDR_EN)
module pipe_reg_em
  import cpu_defs_pkg::*;
#(
  parameter word_t HANDLER_PC = HANDLER_ADR,
  parameter word_t NOP_INSTR  = NOP_WORD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       stall,
  input  logic       bubble,
  input  word_t      instr_E,
  input  word_t      pc_E,
  input  logic       bd_E,
  input  word_t      alu_result_E,
  input  word_t      rt_data_E,
  input  regaddr_t   wa_E,
  input  logic       we_E,
  input  logic       exc_in_E,
  input  logic [4:0] exccode_in_E,
  input  logic       alu_err_E,
  input  logic [4:0] alu_exccode_E,
  output word_t      instr_M,
  output word_t      pc_M,
  output word_t      alu_result_M,
  output word_t      rt_data_M,
  output regaddr_t   wa_M,
  output logic       we_M,
  output logic       bd_M,
  output logic       exc_M,
  output logic [4:0] exccode_M,
  output word_t      badvaddr_M
);

  logic       exc_nxt;
  logic [4:0] exccode_nxt;
  word_t      badvaddr_nxt;

  exc_merge u_exc_merge (
    .exc_in      (exc_in_E),
    .exccode_in  (exccode_in_E),
    .alu_err     (alu_err_E),
    .alu_exccode (alu_exccode_E),
    .pc          (pc_E),
    .alu_result  (alu_result_E),
    .exc         (exc_nxt),
    .exccode     (exccode_nxt),
    .badvaddr    (badvaddr_nxt)
  );

  // Flop bank: reset > req > stall (hold) > bubble > load.
  always_ff @(posedge clk) begin
    if (reset || req) begin
      instr_M      <= NOP_INSTR;
      pc_M         <= reset ? RESET_PC : HANDLER_PC;
      alu_result_M <= '0;
      rt_data_M    <= '0;
      wa_M         <= '0;
      we_M         <= 1'b0;
      bd_M         <= 1'b0;
      exc_M        <= 1'b0;
      exccode_M    <= 5'd0;
    end else if (!stall) begin
      if (bubble) begin
        instr_M      <= NOP_INSTR;
        alu_result_M <= '0;
        rt_data_M    <= '0;
        wa_M         <= '0;
        we_M         <= 1'b0;
        exc_M        <= 1'b0;
        exccode_M    <= 5'd0;
      end else begin
        instr_M      <= instr_E;
        alu_result_M <= alu_result_E;
        rt_data_M    <= rt_data_E;
        wa_M         <= we_E ? wa_E : 5'd0;
        we_M         <= we_E & ~exc_nxt;
        exc_M        <= exc_nxt;
        exccode_M    <= exccode_nxt;
      end
      // pc/bd always follow E so EPC stays precise for a bubble.
      pc_M <= pc_E;
      bd_M <= bd_E;
    end
  end

`ifdef EM_BADVADDR_EN
  // Faulting address register, cleared by reset/req/bubble and held on stall.
  always_ff @(posedge clk) begin
    if (reset || req) begin
      badvaddr_M <= '0;
    end else if (!stall) begin
      badvaddr_M <= bubble ? '0 : badvaddr_nxt;
    end
  end
`else
  word_t badvaddr_unused;
  assign badvaddr_unused = badvaddr_nxt;
  assign badvaddr_M      = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_em.sv
// tb/tb_pipe_reg_em.sv - randomized self-checking bench for pipe_reg_em
module tb_pipe_reg_em;

  logic        clk = 1'b0;
  logic        reset, req, stall, bubble;
  logic [31:0] instr_E, pc_E, alu_result_E, rt_data_E;
  logic        bd_E, we_E, exc_in_E, alu_err_E;
  logic [4:0]  wa_E, exccode_in_E, alu_exccode_E;
  logic [31:0] instr_M, pc_M, alu_result_M, rt_data_M, badvaddr_M;
  logic [4:0]  wa_M, exccode_M;
  logic        we_M, bd_M, exc_M;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  typedef struct {
    logic [31:0] instr, pc, alu, rt, bva;
    logic [4:0]  wa, code;
    logic        we, bd, exc;
  } em_t;

  em_t m;

  pipe_reg_em dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .bubble(bubble),
    .instr_E(instr_E), .pc_E(pc_E), .bd_E(bd_E), .alu_result_E(alu_result_E),
    .rt_data_E(rt_data_E), .wa_E(wa_E), .we_E(we_E), .exc_in_E(exc_in_E),
    .exccode_in_E(exccode_in_E), .alu_err_E(alu_err_E), .alu_exccode_E(alu_exccode_E),
    .instr_M(instr_M), .pc_M(pc_M), .alu_result_M(alu_result_M), .rt_data_M(rt_data_M),
    .wa_M(wa_M), .we_M(we_M), .bd_M(bd_M), .exc_M(exc_M), .exccode_M(exccode_M),
    .badvaddr_M(badvaddr_M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the register must hold after each edge.
  always @(posedge clk) begin
    em_t n;
    n = m;
    if (reset) begin
      n = '{instr: 32'h0, pc: 32'h3000, alu: 0, rt: 0, bva: 0, wa: 0, code: 0, we: 0, bd: 0, exc: 0};
    end else if (req) begin
      n = '{instr: 32'h0, pc: 32'h4180, alu: 0, rt: 0, bva: 0, wa: 0, code: 0, we: 0, bd: 0, exc: 0};
    end else if (stall) begin
      n = m;
    end else if (bubble) begin
      n = '{instr: 32'h0, pc: pc_E, alu: 0, rt: 0, bva: 0, wa: 0, code: 0, we: 0, bd: bd_E, exc: 0};
    end else begin
      n.instr = instr_E;
      n.pc    = pc_E;
      n.bd    = bd_E;
      n.alu   = alu_result_E;
      n.rt    = rt_data_E;
      n.exc   = exc_in_E || alu_err_E;
      n.code  = exc_in_E ? exccode_in_E : (alu_err_E ? alu_exccode_E : 5'd0);
      n.we    = we_E && !n.exc;
      n.wa    = we_E ? wa_E : 5'd0;
      n.bva   = 32'h0;
`ifdef EM_BADVADDR_EN
      if (exc_in_E && exccode_in_E == 5'd4) n.bva = pc_E;
      else if (!exc_in_E && alu_err_E && (alu_exccode_E == 5'd4 || alu_exccode_E == 5'd5)) n.bva = alu_result_E;
`endif
    end
    m = n;
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("instr_M", instr_M, m.instr);
      chk("pc_M", pc_M, m.pc);
      chk("alu_result_M", alu_result_M, m.alu);
      chk("rt_data_M", rt_data_M, m.rt);
      chk("wa_M", {27'd0, wa_M}, {27'd0, m.wa});
      chk("we_M", {31'd0, we_M}, {31'd0, m.we});
      chk("bd_M", {31'd0, bd_M}, {31'd0, m.bd});
      chk("exc_M", {31'd0, exc_M}, {31'd0, m.exc});
      chk("exccode_M", {27'd0, exccode_M}, {27'd0, m.code});
      chk("badvaddr_M", badvaddr_M, m.bva);
    end
  end

  task automatic idle();
    reset = 0; req = 0; stall = 0; bubble = 0;
    instr_E = 0; pc_E = 0; bd_E = 0; alu_result_E = 0; rt_data_E = 0;
    wa_E = 0; we_E = 0; exc_in_E = 0; exccode_in_E = 0; alu_err_E = 0; alu_exccode_E = 0;
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rand_code();
    logic [4:0] codes [6];
    codes = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12};
    if ($urandom_range(3) == 0) return 5'($urandom);
    return codes[$urandom_range(5)];
  endfunction

  initial begin
    idle();
    reset = 1;
    edge_();
    chk("reset pc_M", pc_M, 32'h3000);
    chk("reset instr_M", instr_M, 32'h0);
    chk("reset we_M", {31'd0, we_M}, 32'd0);
    check_en = 1'b1;

    // Plain load
    idle();
    instr_E = 32'h0109_5020; pc_E = 32'h3004; alu_result_E = 32'h10; we_E = 1; wa_E = 5'd10;
    edge_();
    chk("load alu_result_M", alu_result_M, 32'h10);
    chk("load we_M", {31'd0, we_M}, 32'd1);
    chk("load exc_M", {31'd0, exc_M}, 32'd0);
    chk("load wa_M", {27'd0, wa_M}, 32'd10);

    // ALU overflow suppresses write-back
    alu_err_E = 1; alu_exccode_E = 5'd12;
    edge_();
    chk("ov exc_M", {31'd0, exc_M}, 32'd1);
    chk("ov exccode_M", {27'd0, exccode_M}, 32'd12);
    chk("ov we_M", {31'd0, we_M}, 32'd0);

    // Carried exception beats ALU report
    exc_in_E = 1; exccode_in_E = 5'd10; alu_exccode_E = 5'd4;
    edge_();
    chk("prio exccode_M", {27'd0, exccode_M}, 32'd10);
    chk("prio badvaddr_M", badvaddr_M, 32'h0);

    // Store address fault
    idle();
    alu_err_E = 1; alu_exccode_E = 5'd5; alu_result_E = 32'h3; pc_E = 32'h3008;
    edge_();
`ifdef EM_BADVADDR_EN
    chk("ades badvaddr_M", badvaddr_M, 32'h3);
`else
    chk("ades badvaddr_M", badvaddr_M, 32'h0);
`endif

    // Stall holds for two edges, then req wins over stall
    idle();
    instr_E = 32'h0109_5020; pc_E = 32'h3004; alu_result_E = 32'h10; we_E = 1; wa_E = 5'd10;
    edge_();
    stall = 1; instr_E = 32'hDEAD_BEEF; pc_E = 32'h3100; alu_result_E = 32'h77;
    edge_();
    chk("stall1 pc_M", pc_M, 32'h3004);
    chk("stall1 instr_M", instr_M, 32'h0109_5020);
    edge_();
    chk("stall2 alu_result_M", alu_result_M, 32'h10);
    req = 1;
    edge_();
    chk("req pc_M", pc_M, 32'h4180);
    chk("req instr_M", instr_M, 32'h0);

    // Bubble keeps pc/bd, then reset
    idle();
    bubble = 1; pc_E = 32'h3010; bd_E = 1; instr_E = 32'h1234_5678; we_E = 1; wa_E = 5'd3;
    edge_();
    chk("bubble instr_M", instr_M, 32'h0);
    chk("bubble we_M", {31'd0, we_M}, 32'd0);
    chk("bubble pc_M", pc_M, 32'h3010);
    chk("bubble bd_M", {31'd0, bd_M}, 32'd1);
    reset = 1;
    edge_();
    chk("rst pc_M", pc_M, 32'h3000);
    chk("rst bd_M", {31'd0, bd_M}, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(99) == 0);
      req          = ($urandom_range(29) == 0);
      stall        = ($urandom_range(3) == 0);
      bubble       = ($urandom_range(6) == 0);
      instr_E      = $urandom;
      pc_E         = $urandom;
      bd_E         = 1'($urandom);
      alu_result_E = $urandom;
      rt_data_E    = $urandom;
      wa_E         = 5'($urandom);
      we_E         = 1'($urandom);
      exc_in_E     = ($urandom_range(4) == 0);
      exccode_in_E = rand_code();
      alu_err_E    = ($urandom_range(3) == 0);
      alu_exccode_E = rand_code();
      edge_();
    end

    idle();
    edge_();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
